// File: rtl/zl_rs_encoder_framed.sv
// zl_rs_encoder_framed: framed, shortenable systematic RS encoder that passes the message through and then appends the check symbols
module zl_rs_encoder_framed #(
  parameter int N = 255,
  parameter int K = 239,
  parameter int M = 8,
  parameter logic [M*(N-K)-1:0] G_x = '0,
  parameter int Gf_poly = 285
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         data_in_req,
  output logic         data_in_ack,
  input  logic [M-1:0] data_in,
  input  logic         data_in_last,
  output logic         data_out_req,
  input  logic         data_out_ack,
  output logic [M-1:0] data_out,
  output logic         data_out_parity,
  output logic         data_out_last,
  output logic         len_err
);
  localparam int P = N - K;
  localparam logic [M-1:0] poly_lo = M'(Gf_poly);
  typedef enum logic {MSG, PAR} state_t;
  state_t state, next_state;
  logic [M-1:0] sym_cnt, par_cnt, fb;
  logic [P-1:0][M-1:0] r, r_nxt;
  logic in_xfer, out_xfer, sym_last, par_last, step;
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] p, x;
    p = '0;
    x = a;
    for (int j = 0; j < M; j++) begin
      p = b[j] ? p ^ x : p;
      x = x[M-1] ? (x << 1) ^ poly_lo : x << 1;
    end
    return p;
  endfunction
  assign in_xfer = data_in_req & data_in_ack;
  assign out_xfer = data_out_req & data_out_ack;
  assign sym_last = sym_cnt == M'(K - 1);
  assign par_last = par_cnt == M'(P - 1);
  assign fb = r[P-1] ^ data_in;
  assign step = state == MSG ? in_xfer : out_xfer;
  for (genvar i = 0; i < P; i++) begin : g_r
    logic [M-1:0] prev;
    if (i == 0) begin : g_lo
      assign prev = '0;
    end else begin : g_hi
      assign prev = r[i-1];
    end
    assign r_nxt[i] = state == MSG ? prev ^ gf_mul(fb, G_x[M*(i+1)-1 -: M]) : prev;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= MSG;
    else state <= next_state;
  // frame ends on last or on the K-th symbol; parity phase ends after P output transfers
  always_comb
    next_state = state == MSG ? ((in_xfer && (data_in_last || sym_last)) ? PAR : MSG)
                              : ((out_xfer && par_last) ? MSG : PAR);
  // message pass-through in MSG, check register head in PAR with input held off
  always_comb begin
    data_in_ack = state == MSG && data_out_ack;
    data_out_req = state == PAR || data_in_req;
    data_out = state == PAR ? r[P-1] : data_in;
    data_out_parity = state == PAR;
    data_out_last = state == PAR && par_last;
  end
  // LFSR division in MSG, plain shift-out in PAR; counters wrap at frame boundaries
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r <= '0;
      sym_cnt <= '0;
      par_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= state == MSG && in_xfer && sym_last && !data_in_last;
      if (step) r <= r_nxt;
      if (state == MSG && in_xfer) sym_cnt <= next_state == PAR ? '0 : sym_cnt + 1'b1;
      if (state == PAR && out_xfer) par_cnt <= par_last ? '0 : par_cnt + 1'b1;
    end
endmodule
